// File: rtl/tinygpu_pkg.sv
// Shared core-level definitions: writeback source encoding, core pipeline
// states, and the layout of the read-only special registers.
package tinygpu_pkg;

    // Writeback source selected by the decoder.
    typedef enum logic [1:0] {
        ALU      = 2'b00,
        MEMORY   = 2'b01,
        CONSTANT = 2'b10,
        NONE     = 2'b11
    } reg_src_e;

    // Core pipeline states this block reacts to.
    localparam logic [2:0] ST_REQUEST = 3'b011;
    localparam logic [2:0] ST_UPDATE  = 3'b110;

    // The read-only special registers sit at the top of each bank.
    // Each offset is subtracted from NUM_REGS to get the address.
    localparam int unsigned RO_BLOCK_IDX_OFS  = 3;
    localparam int unsigned RO_BLOCK_DIM_OFS  = 2;
    localparam int unsigned RO_THREAD_IDX_OFS = 1;
    localparam int unsigned RO_REG_COUNT      = 3;

    // True when an address falls in the software-writable part of the bank.
    function automatic logic is_writable(input int unsigned addr, input int unsigned num_regs);
        return addr < (num_regs - RO_REG_COUNT);
    endfunction

endpackage

// File: rtl/regfile_lane.sv
// One thread lane: register bank, load scoreboard, UPDATE/load-return
// writeback and the operand latches feeding the ALU/LSU.
module regfile_lane
    import tinygpu_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int NUM_REGS    = 16,
    parameter int ADDR_BITS   = 4,
    parameter int NUM_THREADS = 4,
    parameter int LANE_ID     = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 active,
    input  logic                 stall,
    input  logic [DATA_BITS-1:0] block_id,
    input  logic [2:0]           core_state,
    input  logic [ADDR_BITS-1:0] rd_addr,
    input  logic [ADDR_BITS-1:0] rs_addr,
    input  logic [ADDR_BITS-1:0] rt_addr,
    input  logic                 reg_write_enable,
    input  logic [1:0]           reg_input_mux,
    input  logic [DATA_BITS-1:0] immediate,
    input  logic [DATA_BITS-1:0] alu_data,
    input  logic                 wb_valid,
    input  logic [ADDR_BITS-1:0] wb_rd,
    input  logic [DATA_BITS-1:0] wb_data,
    output logic [DATA_BITS-1:0] rs_out,
    output logic [DATA_BITS-1:0] rt_out,
    output logic                 hz,
    output logic                 busy
);

    localparam int BLOCK_IDX  = NUM_REGS - RO_BLOCK_IDX_OFS;
    localparam int BLOCK_DIM  = NUM_REGS - RO_BLOCK_DIM_OFS;
    localparam int THREAD_IDX = NUM_REGS - RO_THREAD_IDX_OFS;

    logic [DATA_BITS-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]  pending;

    reg_src_e src;
    logic     upd_en;
    logic     wb_en;
    logic     latch_en;

    assign src      = reg_src_e'(reg_input_mux);
    assign upd_en   = active && (core_state == ST_UPDATE) && reg_write_enable
                      && is_writable(32'(rd_addr), NUM_REGS);
    // Returns to non-pending registers are stale (e.g. issued before a reset).
    assign wb_en    = wb_valid && is_writable(32'(wb_rd), NUM_REGS) && pending[wb_rd];
    assign latch_en = active && (core_state == ST_REQUEST) && !stall;

    // This lane blocks REQUEST if any operand, or the destination of a write, is still awaiting a load.
    assign hz   = active && (pending[rs_addr] || pending[rt_addr]
                             || (reg_write_enable && pending[rd_addr]));
    assign busy = |pending;

    // Bank, scoreboard and operand latches; load return first, UPDATE after so UPDATE data wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the bank is reset, not just the scoreboard, because zeroed registers and the special registers are visible to software.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            regs[BLOCK_DIM]  <= DATA_BITS'(NUM_THREADS);
            regs[THREAD_IDX] <= DATA_BITS'(LANE_ID);
            pending          <= '0;
            rs_out           <= '0;
            rt_out           <= '0;
        end else begin
            regs[BLOCK_IDX] <= block_id;

            // NOTE: non-blocking assignments to the same element later in this block override earlier ones; the collision rules rely on that ordering.
            if (wb_en) begin
                regs[wb_rd]    <= wb_data;
                pending[wb_rd] <= 1'b0;
            end

            if (upd_en) begin
                unique case (src)
                    ALU:      regs[rd_addr]    <= alu_data;
                    CONSTANT: regs[rd_addr]    <= immediate;
                    MEMORY:   pending[rd_addr] <= 1'b1;
                    default:  ;
                endcase
            end

            if (latch_en) begin
                rs_out <= regs[rs_addr];
                rt_out <= regs[rt_addr];
            end
        end
    end

endmodule

// File: rtl/simt_register_file.sv
// Core-level SIMT register file: one regfile_lane per thread, with the
// lane hazards combined into a single REQUEST stall and operand handshake.
module simt_register_file
    import tinygpu_pkg::*;
#(
    parameter int  NUM_THREADS = 4,
    parameter int  DATA_BITS   = 8,
    parameter int  NUM_REGS    = 16,
    localparam int ADDR_BITS   = $clog2(NUM_REGS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_THREADS-1:0]           thread_mask,
    input  logic [DATA_BITS-1:0]             block_id,
    input  logic [2:0]                       core_state,
    input  logic [ADDR_BITS-1:0]             rd_addr,
    input  logic [ADDR_BITS-1:0]             rs_addr,
    input  logic [ADDR_BITS-1:0]             rt_addr,
    input  logic                             reg_write_enable,
    input  logic [1:0]                       reg_input_mux,
    input  logic [DATA_BITS-1:0]             immediate,
    input  logic [NUM_THREADS*DATA_BITS-1:0] alu_out,
    input  logic [NUM_THREADS-1:0]           lsu_wb_valid,
    input  logic [NUM_THREADS*ADDR_BITS-1:0] lsu_wb_rd,
    input  logic [NUM_THREADS*DATA_BITS-1:0] lsu_wb_data,
    output logic [NUM_THREADS*DATA_BITS-1:0] rs_out,
    output logic [NUM_THREADS*DATA_BITS-1:0] rt_out,
    output logic                             operand_valid,
    output logic                             hazard,
    output logic [NUM_THREADS-1:0]           lane_busy
);

    logic [NUM_THREADS-1:0] hz_lane;
    logic                   hz_any;

    assign hz_any = |hz_lane;

    for (genvar t = 0; t < NUM_THREADS; t++) begin : g_lane
        regfile_lane #(
            .DATA_BITS   (DATA_BITS),
            .NUM_REGS    (NUM_REGS),
            .ADDR_BITS   (ADDR_BITS),
            .NUM_THREADS (NUM_THREADS),
            .LANE_ID     (t)
        ) u_lane (
            .clk              (clk),
            .reset            (reset),
            .active           (thread_mask[t]),
            .stall            (hz_any),
            .block_id         (block_id),
            .core_state       (core_state),
            .rd_addr          (rd_addr),
            .rs_addr          (rs_addr),
            .rt_addr          (rt_addr),
            .reg_write_enable (reg_write_enable),
            .reg_input_mux    (reg_input_mux),
            .immediate        (immediate),
            .alu_data         (alu_out[t*DATA_BITS +: DATA_BITS]),
            .wb_valid         (lsu_wb_valid[t]),
            .wb_rd            (lsu_wb_rd[t*ADDR_BITS +: ADDR_BITS]),
            .wb_data          (lsu_wb_data[t*DATA_BITS +: DATA_BITS]),
            .rs_out           (rs_out[t*DATA_BITS +: DATA_BITS]),
            .rt_out           (rt_out[t*DATA_BITS +: DATA_BITS]),
            .hz               (hz_lane[t]),
            .busy             (lane_busy[t])
        );
    end

    // Operand handshake: report latch-or-stall one cycle after each REQUEST cycle, idle otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            operand_valid <= 1'b0;
            hazard        <= 1'b0;
        end else if (core_state == ST_REQUEST) begin
            operand_valid <= !hz_any;
            hazard        <= hz_any;
        end else begin
            operand_valid <= 1'b0;
            hazard        <= 1'b0;
        end
    end

endmodule

// File: tb/tb_simt_register_file.sv
// Directed, table-driven bench for simt_register_file (default parameters).
module tb_simt_register_file;

    localparam logic [2:0] S_IDLE = 3'b000;
    localparam logic [2:0] S_REQ  = 3'b011;
    localparam logic [2:0] S_UPD  = 3'b110;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  thread_mask;
    logic [7:0]  block_id;
    logic [2:0]  core_state;
    logic [3:0]  rd_addr, rs_addr, rt_addr;
    logic        reg_write_enable;
    logic [1:0]  reg_input_mux;
    logic [7:0]  immediate;
    logic [31:0] alu_out;
    logic [3:0]  lsu_wb_valid;
    logic [15:0] lsu_wb_rd;
    logic [31:0] lsu_wb_data;
    logic [31:0] rs_out, rt_out;
    logic        operand_valid, hazard;
    logic [3:0]  lane_busy;

    int tests  = 0;
    int errors = 0;

    simt_register_file dut (
        .clk              (clk),
        .reset            (reset),
        .thread_mask      (thread_mask),
        .block_id         (block_id),
        .core_state       (core_state),
        .rd_addr          (rd_addr),
        .rs_addr          (rs_addr),
        .rt_addr          (rt_addr),
        .reg_write_enable (reg_write_enable),
        .reg_input_mux    (reg_input_mux),
        .immediate        (immediate),
        .alu_out          (alu_out),
        .lsu_wb_valid     (lsu_wb_valid),
        .lsu_wb_rd        (lsu_wb_rd),
        .lsu_wb_data      (lsu_wb_data),
        .rs_out           (rs_out),
        .rt_out           (rt_out),
        .operand_valid    (operand_valid),
        .hazard           (hazard),
        .lane_busy        (lane_busy)
    );

    always #5 clk = ~clk;

    // One clock of stimulus plus the outputs expected just after that edge.
    typedef struct {
        string       name;
        logic        rst;
        logic [2:0]  st;
        logic [3:0]  mask;
        logic [3:0]  rs, rt, rd;
        logic        we;
        logic [1:0]  mux;
        logic [7:0]  imm;
        logic [31:0] alu;
        logic [3:0]  wbv;
        logic [15:0] wbrd;
        logic [31:0] wbd;
        logic        ov, hz;
        logic [31:0] rs_exp, rt_exp;
        logic [3:0]  busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string name, logic rst, logic [2:0] st, logic [3:0] mask,
                                logic [3:0] rs, logic [3:0] rt, logic [3:0] rd, logic we,
                                logic [1:0] mux, logic [7:0] imm, logic [31:0] alu,
                                logic [3:0] wbv, logic [15:0] wbrd, logic [31:0] wbd,
                                logic ov, logic hz, logic [31:0] rs_exp, logic [31:0] rt_exp,
                                logic [3:0] busy);
        vec_t v;
        v.name = name; v.rst = rst; v.st = st; v.mask = mask;
        v.rs = rs; v.rt = rt; v.rd = rd; v.we = we; v.mux = mux; v.imm = imm; v.alu = alu;
        v.wbv = wbv; v.wbrd = wbrd; v.wbd = wbd;
        v.ov = ov; v.hz = hz; v.rs_exp = rs_exp; v.rt_exp = rt_exp; v.busy = busy;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, actual, expected);
        end
    endtask

    task automatic step(input vec_t v);
        reset            = v.rst;
        core_state       = v.st;
        thread_mask      = v.mask;
        rs_addr          = v.rs;
        rt_addr          = v.rt;
        rd_addr          = v.rd;
        reg_write_enable = v.we;
        reg_input_mux    = v.mux;
        immediate        = v.imm;
        alu_out          = v.alu;
        lsu_wb_valid     = v.wbv;
        lsu_wb_rd        = v.wbrd;
        lsu_wb_data      = v.wbd;
        @(posedge clk);
        #1;
        check({v.name, ".operand_valid"}, 32'(operand_valid), 32'(v.ov));
        check({v.name, ".hazard"},        32'(hazard),        32'(v.hz));
        check({v.name, ".rs_out"},        rs_out,             v.rs_exp);
        check({v.name, ".rt_out"},        rt_out,             v.rt_exp);
        check({v.name, ".lane_busy"},     32'(lane_busy),     32'(v.busy));
    endtask

    initial begin
        block_id = 8'd7;

        // Reset state, then the main read/write/load paths.
        //             name         rst st      mask   rs  rt  rd  we mux    imm    alu           wbv    wbrd      wbd           ov hz rs_exp        rt_exp        busy
        tbl.push_back(mk("rst0",    1, S_IDLE, 4'hF,  0,  0,  0,  0, 2'b11, 8'h00, 32'h0,        4'h0, 16'h0000, 32'h0,        0, 0, 32'h00000000, 32'h00000000, 4'h0));
        tbl.push_back(mk("rst1",    1, S_REQ,  4'hF,  14, 15, 0,  0, 2'b11, 8'h00, 32'h0,        4'h0, 16'h0000, 32'h0,        0, 0, 32'h00000000, 32'h00000000, 4'h0));
        tbl.push_back(mk("rd_ro",   0, S_REQ,  4'hF,  14, 15, 0,  0, 2'b11, 8'h00, 32'h0,        4'h0, 16'h0000, 32'h0,        1, 0, 32'h04040404, 32'h03020100, 4'h0));
        tbl.push_back(mk("upd_imm", 0, S_UPD,  4'hB,  0,  0,  2,  1, 2'b10, 8'h5A, 32'h0,        4'h0, 16'h0000, 32'h0,        0, 0, 32'h04040404, 32'h03020100, 4'h0));
        tbl.push_back(mk("rd_imm",  0, S_REQ,  4'hF,  2,  13, 0,  0, 2'b11, 8'h00, 32'h0,        4'h0, 16'h0000, 32'h0,        1, 0, 32'h5A005A5A, 32'h07070707, 4'h0));
        tbl.push_back(mk("upd_ld",  0, S_UPD,  4'hF,  0,  0,  4,  1, 2'b01, 8'h00, 32'h0,        4'h0, 16'h0000, 32'h0,        0, 0, 32'h5A005A5A, 32'h07070707, 4'hF));
        tbl.push_back(mk("stall1",  0, S_REQ,  4'hF,  4,  0,  0,  0, 2'b11, 8'h00, 32'h0,        4'h0, 16'h0000, 32'h0,        0, 1, 32'h5A005A5A, 32'h07070707, 4'hF));
        tbl.push_back(mk("stall2",  0, S_REQ,  4'hF,  4,  0,  0,  0, 2'b11, 8'h00, 32'h0,        4'h0, 16'h0000, 32'h0,        0, 1, 32'h5A005A5A, 32'h07070707, 4'hF));
        tbl.push_back(mk("stall3",  0, S_REQ,  4'hF,  4,  0,  0,  0, 2'b11, 8'h00, 32'h0,        4'h0, 16'h0000, 32'h0,        0, 1, 32'h5A005A5A, 32'h07070707, 4'hF));
        tbl.push_back(mk("ret_all", 0, S_REQ,  4'hF,  4,  0,  0,  0, 2'b11, 8'h00, 32'h0,        4'hF, 16'h4444, 32'h0D0C0B0A, 0, 1, 32'h5A005A5A, 32'h07070707, 4'h0));
        tbl.push_back(mk("rd_ld",   0, S_REQ,  4'hF,  4,  0,  0,  0, 2'b11, 8'h00, 32'h0,        4'h0, 16'h0000, 32'h0,        1, 0, 32'h0D0C0B0A, 32'h00000000, 4'h0));
        tbl.push_back(mk("wr_ro",   0, S_UPD,  4'hF,  0,  0,  13, 1, 2'b00, 8'h00, 32'hFFFFFFFF, 4'h1, 16'h000F, 32'h00000055, 0, 0, 32'h0D0C0B0A, 32'h00000000, 4'h0));
        tbl.push_back(mk("rd_ro2",  0, S_REQ,  4'hF,  13, 15, 0,  0, 2'b11, 8'h00, 32'h0,        4'h0, 16'h0000, 32'h0,        1, 0, 32'h07070707, 32'h03020100, 4'h0));
        tbl.push_back(mk("ld_ro",   0, S_UPD,  4'hF,  0,  0,  14, 1, 2'b01, 8'h00, 32'h0,        4'h0, 16'h0000, 32'h0,        0, 0, 32'h07070707, 32'h03020100, 4'h0));
        tbl.push_back(mk("rd_ro3",  0, S_REQ,  4'hF,  14, 14, 0,  0, 2'b11, 8'h00, 32'h0,        4'h0, 16'h0000, 32'h0,        1, 0, 32'h04040404, 32'h04040404, 4'h0));
        tbl.push_back(mk("upd_none",0, S_UPD,  4'hF,  0,  0,  0,  1, 2'b11, 8'h66, 32'h66666666, 4'h0, 16'h0000, 32'h0,        0, 0, 32'h04040404, 32'h04040404, 4'h0));
        tbl.push_back(mk("rd_none", 0, S_REQ,  4'hF,  0,  2,  0,  0, 2'b11, 8'h00, 32'h0,        4'h0, 16'h0000, 32'h0,        1, 0, 32'h00000000, 32'h5A005A5A, 4'h0));

        foreach (tbl[i]) step(tbl[i]);

        // Reset with a load outstanding: the late return must be dropped.
        step(mk("a_ld",     0, S_UPD,  4'h2,  0,  0,  4,  1, 2'b01, 8'h00, 32'h0,        4'h0, 16'h0000, 32'h0,        0, 0, 32'h00000000, 32'h5A005A5A, 4'h2));
        step(mk("a_rst",    1, S_IDLE, 4'hF,  0,  0,  0,  0, 2'b11, 8'h00, 32'h0,        4'h0, 16'h0000, 32'h0,        0, 0, 32'h00000000, 32'h00000000, 4'h0));
        step(mk("a_stale",  0, S_IDLE, 4'hF,  0,  0,  0,  0, 2'b11, 8'h00, 32'h0,        4'h2, 16'h0040, 32'h00003300, 0, 0, 32'h00000000, 32'h00000000, 4'h0));
        step(mk("a_rd",     0, S_REQ,  4'hF,  4,  4,  0,  0, 2'b11, 8'h00, 32'h0,        4'h0, 16'h0000, 32'h0,        1, 0, 32'h00000000, 32'h00000000, 4'h0));

        // Destination hazard, then UPDATE ALU colliding with a return: ALU data wins, pending cleared.
        step(mk("b_ld",     0, S_UPD,  4'h1,  0,  0,  5,  1, 2'b01, 8'h00, 32'h0,        4'h0, 16'h0000, 32'h0,        0, 0, 32'h00000000, 32'h00000000, 4'h1));
        step(mk("b_rdhz",   0, S_REQ,  4'hF,  0,  0,  5,  1, 2'b00, 8'h00, 32'h0,        4'h0, 16'h0000, 32'h0,        0, 1, 32'h00000000, 32'h00000000, 4'h1));
        step(mk("b_coll",   0, S_UPD,  4'h1,  0,  0,  5,  1, 2'b00, 8'h00, 32'h00000021, 4'h1, 16'h0005, 32'h00000099, 0, 0, 32'h00000000, 32'h00000000, 4'h0));
        step(mk("b_rd",     0, S_REQ,  4'hF,  5,  5,  0,  0, 2'b11, 8'h00, 32'h0,        4'h0, 16'h0000, 32'h0,        1, 0, 32'h00000021, 32'h00000021, 4'h0));

        // UPDATE MEMORY colliding with a return: data written, pending stays set.
        step(mk("c_ld",     0, S_UPD,  4'h1,  0,  0,  6,  1, 2'b01, 8'h00, 32'h0,        4'h0, 16'h0000, 32'h0,        0, 0, 32'h00000021, 32'h00000021, 4'h1));
        step(mk("c_coll",   0, S_UPD,  4'h1,  0,  0,  6,  1, 2'b01, 8'h00, 32'h0,        4'h1, 16'h0006, 32'h00000077, 0, 0, 32'h00000021, 32'h00000021, 4'h1));
        step(mk("c_hz",     0, S_REQ,  4'hF,  6,  0,  0,  0, 2'b11, 8'h00, 32'h0,        4'h0, 16'h0000, 32'h0,        0, 1, 32'h00000021, 32'h00000021, 4'h1));
        step(mk("c_ret",    0, S_IDLE, 4'h0,  0,  0,  0,  0, 2'b11, 8'h00, 32'h0,        4'h1, 16'h0006, 32'h00000088, 0, 0, 32'h00000021, 32'h00000021, 4'h0));
        step(mk("c_rd",     0, S_REQ,  4'hF,  6,  0,  0,  0, 2'b11, 8'h00, 32'h0,        4'h0, 16'h0000, 32'h0,        1, 0, 32'h00000088, 32'h00000000, 4'h0));

        // A pending load in a masked-off lane does not stall; the return is taken with the lane inactive.
        step(mk("d_ld",     0, S_UPD,  4'h4,  0,  0,  7,  1, 2'b01, 8'h00, 32'h0,        4'h0, 16'h0000, 32'h0,        0, 0, 32'h00000088, 32'h00000000, 4'h4));
        step(mk("d_mask",   0, S_REQ,  4'hB,  7,  7,  0,  0, 2'b11, 8'h00, 32'h0,        4'h0, 16'h0000, 32'h0,        1, 0, 32'h00000000, 32'h00000000, 4'h4));
        step(mk("d_ret",    0, S_IDLE, 4'h0,  0,  0,  0,  0, 2'b11, 8'h00, 32'h0,        4'h4, 16'h0700, 32'h00440000, 0, 0, 32'h00000000, 32'h00000000, 4'h0));
        step(mk("d_rd",     0, S_REQ,  4'hF,  7,  2,  0,  0, 2'b11, 8'h00, 32'h0,        4'h0, 16'h0000, 32'h0,        1, 0, 32'h00440000, 32'h00000000, 4'h0));

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
